// File: rtl/i2c_sht40_target.sv
// I2C target emulating an SHT40 sensor: one command byte on writes, a 6-byte
// temperature/humidity frame with CRC-8 on reads. SDA is open-drain; SCL is input only.
module i2c_sht40_target #(
   parameter logic [6:0] TARGET_ADDR = 7'h44,
   parameter logic [7:0] CRC_POLY    = 8'h31,
   parameter logic [7:0] CRC_INIT    = 8'hFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        Scl_Data,
   inout  wire         Sda_Data,
   input  logic [15:0] Meas_Temp,
   input  logic [15:0] Meas_Rh,
   output logic [7:0]  Cmd_Byte,
   output logic        Cmd_Valid,
   output logic        Busy,
   output logic [2:0]  Bytes_Sent,
   output logic [2:0]  Target_State_Out
);

   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned WORD_W    = 16;
   localparam int unsigned CNT_W     = 4;
   localparam int unsigned IDX_W     = 3;
   localparam int unsigned SYNC_W    = 3;
   localparam int unsigned FRAME_LEN = 6;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ADDR     = 3'd1,
      S_ADDR_ACK = 3'd2,
      S_CMD      = 3'd3,
      S_CMD_ACK  = 3'd4,
      S_TX       = 3'd5,
      S_TX_ACK   = 3'd6,
      S_IGNORE   = 3'd7
   } state_e;

   function automatic logic [BYTE_W-1:0] crc8(input logic [WORD_W-1:0] data);
      logic [BYTE_W-1:0] crc;
      crc = CRC_INIT;
      for (int i = WORD_W - 1; i >= 0; i--) begin
         if (crc[BYTE_W-1] ^ data[i]) crc = {crc[BYTE_W-2:0], 1'b0} ^ CRC_POLY;
         else                         crc = {crc[BYTE_W-2:0], 1'b0};
      end
      return crc;
   endfunction

   // Frame byte for a given index; past the end the line stays released (all ones).
   function automatic logic [BYTE_W-1:0] frame_byte(input logic [IDX_W-1:0] idx,
                                                    input logic [WORD_W-1:0] t,
                                                    input logic [WORD_W-1:0] rh);
      case (idx)
         3'd0:    return t[15:8];
         3'd1:    return t[7:0];
         3'd2:    return crc8(t);
         3'd3:    return rh[15:8];
         3'd4:    return rh[7:0];
         3'd5:    return crc8(rh);
         default: return 8'hFF;
      endcase
   endfunction

   logic [SYNC_W-1:0] scl_sync_q, scl_sync_d;
   logic [SYNC_W-1:0] sda_sync_q, sda_sync_d;
   state_e            state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [BYTE_W-1:0] shift_q, shift_d;
   logic [BYTE_W-1:0] tx_q, tx_d;
   logic              sda_oe_q, sda_oe_d;
   logic [BYTE_W-1:0] cmd_byte_q, cmd_byte_d;
   logic              cmd_valid_q, cmd_valid_d;
   logic              busy_q, busy_d;
   logic [IDX_W-1:0]  bytes_sent_q, bytes_sent_d;
   logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
   logic              rw_q, rw_d;
   logic [WORD_W-1:0] temp_q, temp_d;
   logic [WORD_W-1:0] rh_q, rh_d;

   logic scl_rise_c, scl_fall_c, start_c, stop_c, sda_in_c;
   logic [IDX_W-1:0]  idx_next_c;
   logic [BYTE_W-1:0] byte0_c, next_byte_c;

   assign Sda_Data = sda_oe_q ? 1'b0 : 1'bz;

   // Edge and bus-condition detection on the second synchronizer stage.
   always_comb begin
      scl_sync_d = {scl_sync_q[SYNC_W-2:0], Scl_Data};
      sda_sync_d = {sda_sync_q[SYNC_W-2:0], Sda_Data};
      sda_in_c   = sda_sync_q[1];
      scl_rise_c = scl_sync_q[1] & ~scl_sync_q[2];
      scl_fall_c = ~scl_sync_q[1] & scl_sync_q[2];
      start_c    = scl_sync_q[1] & scl_sync_q[2] & sda_sync_q[2] & ~sda_sync_q[1];
      stop_c     = scl_sync_q[1] & scl_sync_q[2] & ~sda_sync_q[2] & sda_sync_q[1];
      idx_next_c = (byte_idx_q < IDX_W'(FRAME_LEN)) ? byte_idx_q + 1'b1 : byte_idx_q;
      byte0_c     = Meas_Temp[15:8];
      next_byte_c = frame_byte(idx_next_c, temp_q, rh_q);
   end

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      tx_d         = tx_q;
      sda_oe_d     = sda_oe_q;
      cmd_byte_d   = cmd_byte_q;
      cmd_valid_d  = 1'b0;
      busy_d       = busy_q;
      bytes_sent_d = bytes_sent_q;
      byte_idx_d   = byte_idx_q;
      rw_d         = rw_q;
      temp_d       = temp_q;
      rh_d         = rh_q;

      if (start_c) begin
         state_d      = S_ADDR;
         bit_cnt_d    = '0;
         sda_oe_d     = 1'b0;
         bytes_sent_d = '0;
      end else if (stop_c) begin
         state_d  = S_IDLE;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else begin
         case (state_q)
            S_ADDR, S_CMD: begin
               if (scl_rise_c && bit_cnt_q < CNT_W'(BYTE_W)) begin
                  shift_d   = {shift_q[BYTE_W-2:0], sda_in_c};
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end else if (scl_fall_c && bit_cnt_q == CNT_W'(BYTE_W)) begin
                  if (state_q == S_CMD) begin
                     cmd_byte_d  = shift_q;
                     cmd_valid_d = 1'b1;
                     sda_oe_d    = 1'b1;
                     state_d     = S_CMD_ACK;
                  end else if (shift_q[BYTE_W-1:1] == TARGET_ADDR) begin
                     rw_d     = shift_q[0];
                     busy_d   = 1'b1;
                     sda_oe_d = 1'b1;
                     state_d  = S_ADDR_ACK;
                  end else begin
                     busy_d  = 1'b0;
                     state_d = S_IGNORE;
                  end
               end
            end
            S_ADDR_ACK: begin
               if (scl_fall_c) begin
                  bit_cnt_d = '0;
                  sda_oe_d  = 1'b0;
                  state_d   = S_CMD;
                  if (rw_q) begin
                     // Latch the words and present the first bit on this same fall.
                     temp_d     = Meas_Temp;
                     rh_d       = Meas_Rh;
                     byte_idx_d = '0;
                     sda_oe_d   = ~byte0_c[BYTE_W-1];
                     tx_d       = {byte0_c[BYTE_W-2:0], 1'b1};
                     bit_cnt_d  = CNT_W'(1);
                     state_d    = S_TX;
                  end
               end
            end
            S_CMD_ACK: begin
               if (scl_fall_c) begin
                  sda_oe_d = 1'b0;
                  state_d  = S_IGNORE;
               end
            end
            S_TX: begin
               if (scl_fall_c) begin
                  if (bit_cnt_q < CNT_W'(BYTE_W)) begin
                     sda_oe_d  = ~tx_q[BYTE_W-1];
                     tx_d      = {tx_q[BYTE_W-2:0], 1'b1};
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end else begin
                     sda_oe_d = 1'b0;
                     if (bytes_sent_q < IDX_W'(FRAME_LEN)) bytes_sent_d = bytes_sent_q + 1'b1;
                     state_d = S_TX_ACK;
                  end
               end
            end
            S_TX_ACK: begin
               if (scl_rise_c) begin
                  if (!sda_in_c) begin
                     byte_idx_d = idx_next_c;
                     tx_d       = next_byte_c;
                     bit_cnt_d  = '0;
                     state_d    = S_TX;
                  end else begin
                     state_d = S_IGNORE;
                  end
               end
            end
            S_IGNORE: sda_oe_d = 1'b0;
            default:  state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync_q   <= '1;
         sda_sync_q   <= '1;
         state_q      <= S_IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         tx_q         <= '1;
         sda_oe_q     <= 1'b0;
         cmd_byte_q   <= '0;
         cmd_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         bytes_sent_q <= '0;
         byte_idx_q   <= '0;
         rw_q         <= 1'b0;
         temp_q       <= '0;
         rh_q         <= '0;
      end else begin
         scl_sync_q   <= scl_sync_d;
         sda_sync_q   <= sda_sync_d;
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         tx_q         <= tx_d;
         sda_oe_q     <= sda_oe_d;
         cmd_byte_q   <= cmd_byte_d;
         cmd_valid_q  <= cmd_valid_d;
         busy_q       <= busy_d;
         bytes_sent_q <= bytes_sent_d;
         byte_idx_q   <= byte_idx_d;
         rw_q         <= rw_d;
         temp_q       <= temp_d;
         rh_q         <= rh_d;
      end
   end

   assign Cmd_Byte         = cmd_byte_q;
   assign Cmd_Valid        = cmd_valid_q;
   assign Busy             = busy_q;
   assign Bytes_Sent       = bytes_sent_q;
   assign Target_State_Out = state_q;

endmodule

// File: tb/tb_i2c_sht40_target.sv
// Directed bench for i2c_sht40_target: a bit-banged I2C master on a pulled-up SDA line,
// checking ACKs, command capture, read frames with CRC, and reset release.
module tb_i2c_sht40_target;

   localparam int Q = 10;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        scl;
   logic        m_low;
   logic [15:0] meas_temp, meas_rh;
   wire  [7:0]  cmd_byte;
   wire         cmd_valid, busy;
   wire  [2:0]  bytes_sent, state;
   wire         sda_bus;

   pullup (sda_bus);
   assign sda_bus = m_low ? 1'b0 : 1'bz;

   i2c_sht40_target dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .Scl_Data         (scl),
      .Sda_Data         (sda_bus),
      .Meas_Temp        (meas_temp),
      .Meas_Rh          (meas_rh),
      .Cmd_Byte         (cmd_byte),
      .Cmd_Valid        (cmd_valid),
      .Busy             (busy),
      .Bytes_Sent       (bytes_sent),
      .Target_State_Out (state)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   cv_cnt = 0;
   int   drv_cnt = 0;
   logic watch = 1'b0;

   logic [7:0] beef_frame [6] = '{8'hBE, 8'hEF, 8'h92, 8'hBE, 8'hEF, 8'h92};

   // Count Cmd_Valid pulses and any target pull-down while the master has released the line.
   always @(negedge clk) begin
      if (cmd_valid) cv_cnt <= cv_cnt + 1;
      if (watch && !m_low && sda_bus === 1'b0) drv_cnt <= drv_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bit_xfer(input logic b, output logic r);
      m_low = ~b;
      tick(Q);
      scl = 1'b1;
      tick(Q);
      r = sda_bus;
      scl = 1'b0;
      tick(Q);
   endtask

   task automatic i2c_start;
      m_low = 1'b0; tick(Q);
      m_low = 1'b1; tick(Q);
      scl = 1'b0;   tick(Q);
   endtask

   task automatic i2c_rstart;
      m_low = 1'b0; tick(Q);
      scl = 1'b1;   tick(Q);
      m_low = 1'b1; tick(Q);
      scl = 1'b0;   tick(Q);
   endtask

   task automatic i2c_stop;
      m_low = 1'b1; tick(Q);
      scl = 1'b1;   tick(Q);
      m_low = 1'b0; tick(Q);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
      bit_xfer(1'b1, r);
      ack = ~r;
   endtask

   task automatic read_byte(input logic ack, output logic [7:0] b);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, r);
         b[i] = r;
      end
      bit_xfer(~ack, r);
   endtask

   initial begin
      logic       ack, r;
      logic [7:0] b;
      int         cv0, d0;

      rst_n = 1'b0; scl = 1'b1; m_low = 1'b0;
      meas_temp = 16'hBEEF; meas_rh = 16'hBEEF;
      tick(4);
      check("rst_sda", 32'(sda_bus), 1);
      check("rst_state", 32'(state), 0);
      check("rst_cmd_byte", 32'(cmd_byte), 0);
      check("rst_cmd_valid", 32'(cmd_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_bytes_sent", 32'(bytes_sent), 0);
      rst_n = 1'b1;
      tick(4);

      // Write command 0xFD
      cv0 = cv_cnt;
      i2c_start;
      write_byte(8'h88, ack);
      check("t1_addr_ack", 32'(ack), 1);
      check("t1_busy", 32'(busy), 1);
      write_byte(8'hFD, ack);
      check("t1_cmd_ack", 32'(ack), 1);
      check("t1_cmd_byte", 32'(cmd_byte), 'hFD);
      check("t1_cmd_valid_pulses", 32'(cv_cnt - cv0), 1);
      check("t1_state_ignore", 32'(state), 7);
      i2c_stop;
      check("t1_busy_after_stop", 32'(busy), 0);
      check("t1_state_idle", 32'(state), 0);

      // Full 6-byte read of 0xBEEF/0xBEEF
      i2c_start;
      write_byte(8'h89, ack);
      check("t2_addr_ack", 32'(ack), 1);
      for (int k = 0; k < 6; k++) begin
         read_byte(k < 5, b);
         check($sformatf("t2_byte%0d", k), 32'(b), 32'(beef_frame[k]));
      end
      check("t2_bytes_sent", 32'(bytes_sent), 6);
      i2c_stop;

      // Foreign address 0x45: line never driven
      watch = 1'b1;
      d0 = drv_cnt; cv0 = cv_cnt;
      i2c_start;
      write_byte(8'h8A, ack);
      check("t3_addr_nack", 32'(ack), 0);
      check("t3_busy", 32'(busy), 0);
      check("t3_state_ignore", 32'(state), 7);
      write_byte(8'h00, ack);
      check("t3_data_nack", 32'(ack), 0);
      i2c_stop;
      watch = 1'b0;
      check("t3_sda_driven_cycles", 32'(drv_cnt - d0), 0);
      check("t3_cmd_valid_pulses", 32'(cv_cnt - cv0), 0);

      // Master NACKs after byte 2
      i2c_start;
      write_byte(8'h89, ack);
      check("t4_addr_ack", 32'(ack), 1);
      read_byte(1'b1, b);
      check("t4_byte0", 32'(b), 'hBE);
      read_byte(1'b0, b);
      check("t4_byte1", 32'(b), 'hEF);
      check("t4_sda_released", 32'(sda_bus), 1);
      check("t4_state_ignore", 32'(state), 7);
      check("t4_bytes_sent", 32'(bytes_sent), 2);
      i2c_stop;
      check("t4_state_idle", 32'(state), 0);

      // Write, repeated START, read; temperature changes after the address ACK
      meas_temp = 16'h1234;
      i2c_start;
      write_byte(8'h88, ack);
      check("t5_waddr_ack", 32'(ack), 1);
      write_byte(8'hFD, ack);
      check("t5_cmd_ack", 32'(ack), 1);
      i2c_rstart;
      write_byte(8'h89, ack);
      check("t5_raddr_ack", 32'(ack), 1);
      check("t5_busy", 32'(busy), 1);
      meas_temp = 16'hABCD;
      read_byte(1'b1, b);
      check("t5_byte0", 32'(b), 'h12);
      read_byte(1'b0, b);
      check("t5_byte1", 32'(b), 'h34);
      i2c_stop;

      // Reset while the target drives bit 4 of byte 1 (0xEF bit 4 = 0)
      meas_temp = 16'hBEEF;
      i2c_start;
      write_byte(8'h89, ack);
      check("t6_addr_ack", 32'(ack), 1);
      read_byte(1'b1, b);
      check("t6_byte0", 32'(b), 'hBE);
      for (int i = 0; i < 3; i++) bit_xfer(1'b1, r);
      m_low = 1'b0;
      check("t6_driving_before_reset", 32'(sda_bus), 0);
      rst_n = 1'b0;
      #1;
      check("t6_sda_released", 32'(sda_bus), 1);
      check("t6_state", 32'(state), 0);
      check("t6_busy", 32'(busy), 0);
      check("t6_bytes_sent", 32'(bytes_sent), 0);
      check("t6_cmd_byte", 32'(cmd_byte), 0);
      check("t6_cmd_valid", 32'(cmd_valid), 0);
      tick(3);
      rst_n = 1'b1;
      tick(Q);
      scl = 1'b1;
      tick(Q);
      i2c_start;
      write_byte(8'h89, ack);
      check("t6_re_addr_ack", 32'(ack), 1);
      for (int k = 0; k < 6; k++) begin
         read_byte(k < 5, b);
         check($sformatf("t6_byte%0d", k), 32'(b), 32'(beef_frame[k]));
      end
      i2c_stop;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
